iq_polar_cordic: RTL and testbench



---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_atan_rom.sv | 13 +
 rtl/iq_polar_cordic.sv | 143 ++++++++++++++
 tb/tb_iq_polar_cordic.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, atan table and FSM states for the vectoring CORDIC.
package cordic_pkg;

  localparam int unsigned ATAN_IDX_W   = 4;
  localparam int unsigned ATAN_SCALE_W = 16;

  // 1/1.6468 in Q0.11, removes the CORDIC gain from the magnitude
  localparam logic [12:0] KOEF_MASH = 13'h4DB;

  // round(atan(2^-i) * 2^16 / 2pi), i = 0..15
  localparam logic [ATAN_SCALE_W-1:0] ATAN_TABLE [16] = '{
    16'h2000, 16'h12E4, 16'h09FB, 16'h0511,
    16'h028B, 16'h0146, 16'h00A3, 16'h0051,
    16'h0029, 16'h0014, 16'h000A, 16'h0005,
    16'h0003, 16'h0001, 16'h0001, 16'h0000
  };

  typedef enum logic [1:0] {IDLE, FOLD, ITER, DONE} cordic_state_e;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan lookup, scaled down from the 16-bit table to WIDTH_ANGLE.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH_ANGLE = 16
) (
  input  logic [ATAN_IDX_W-1:0]  idx,
  output logic [WIDTH_ANGLE-1:0] atan_c
);

  assign atan_c = WIDTH_ANGLE'(ATAN_TABLE[idx] >> (ATAN_SCALE_W - WIDTH_ANGLE));

endmodule

// File: rtl/iq_polar_cordic.sv
// Iterative vectoring CORDIC: I/Q sample in, magnitude and phase out.
// Define GAIN_COMP_EN to scale the magnitude by 1/1.6468 before it is registered.
module iq_polar_cordic
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH_DATA  = 12,
  parameter int unsigned WIDTH_ANGLE = 16,
  parameter int unsigned ITERATIONS  = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [WIDTH_DATA-1:0]  I_i,
  input  logic signed [WIDTH_DATA-1:0]  Q_i,
  output logic                          out_valid,
  output logic        [WIDTH_DATA:0]    mag_o,
  output logic        [WIDTH_ANGLE-1:0] phase_o
);

  localparam int unsigned XW = WIDTH_DATA + 2;
  localparam int unsigned MW = WIDTH_DATA + 1;
  localparam int unsigned CW = $clog2(ITERATIONS);
  localparam logic [WIDTH_ANGLE-1:0] HALF_TURN = {1'b1, (WIDTH_ANGLE-1)'(0)};

  cordic_state_e           state_q, state_d;
  logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
  logic [WIDTH_ANGLE-1:0]  z_q, z_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    zero_q, zero_d;
  logic                    in_ready_d, out_valid_d;
  logic [MW-1:0]           mag_d;
  logic [WIDTH_ANGLE-1:0]  phase_d;

  logic [WIDTH_ANGLE-1:0]  atan_c;
  logic signed [XW-1:0]    x_step_c, y_step_c;
  logic [WIDTH_ANGLE-1:0]  z_step_c;
  logic [MW-1:0]           mag_next_c;

  cordic_atan_rom #(.WIDTH_ANGLE(WIDTH_ANGLE)) u_atan_rom (
    .idx    (ATAN_IDX_W'(cnt_q)),
    .atan_c (atan_c)
  );

  // One micro-rotation; shifts use the pre-update x/y
  always_comb begin
    x_step_c = x_q;
    y_step_c = y_q;
    z_step_c = z_q;
    if (!y_q[XW-1]) begin
      x_step_c = x_q + (y_q >>> cnt_q);
      y_step_c = y_q - (x_q >>> cnt_q);
      if (!zero_q) z_step_c = z_q + atan_c;
    end else begin
      x_step_c = x_q - (y_q >>> cnt_q);
      y_step_c = y_q + (x_q >>> cnt_q);
      if (!zero_q) z_step_c = z_q - atan_c;
    end
  end

`ifdef GAIN_COMP_EN
  assign mag_next_c = MW'(((MW+11)'(MW'(x_step_c)) * (MW+11)'(KOEF_MASH)) >> 11);
`else
  assign mag_next_c = MW'(x_step_c);
`endif

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    mag_d       = mag_o;
    phase_d     = phase_o;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = XW'(I_i);
          y_d     = XW'(Q_i);
          state_d = FOLD;
        end
      end
      FOLD: begin
        // Left half-plane is mirrored through the origin so x starts non-negative
        zero_d = (x_q == '0) && (y_q == '0);
        cnt_d  = '0;
        if (x_q[XW-1]) begin
          x_d = -x_q;
          y_d = -y_q;
          z_d = HALF_TURN;
        end else begin
          z_d = '0;
        end
        state_d = ITER;
      end
      ITER: begin
        x_d = x_step_c;
        y_d = y_step_c;
        z_d = z_step_c;
        if (cnt_q == CW'(ITERATIONS - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          mag_d       = mag_next_c;
          phase_d     = z_step_c;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mag_o     <= '0;
      phase_o   <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      cnt_q     <= cnt_d;
      zero_q    <= zero_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      mag_o     <= mag_d;
      phase_o   <= phase_d;
    end
  end

endmodule

// File: tb/tb_iq_polar_cordic.sv
// Bench for iq_polar_cordic: cycle-level transaction model plus ideal atan2/hypot sanity.
module tb_iq_polar_cordic;

  localparam int unsigned WD = 12;
  localparam int unsigned WA = 16;
  localparam int unsigned IT = 14;
  localparam real PI = 3.14159265358979;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [WD-1:0] i_s = '0;
  logic signed [WD-1:0] q_s = '0;
  logic                 out_valid;
  logic [WD:0]          mag;
  logic [WA-1:0]        phase;

  iq_polar_cordic #(.WIDTH_DATA(WD), .WIDTH_ANGLE(WA), .ITERATIONS(IT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .I_i       (i_s),
    .Q_i       (q_s),
    .out_valid (out_valid),
    .mag_o     (mag),
    .phase_o   (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_n;
    int i;
    int q;
  } txn_t;

  txn_t pend[$];
  int   edge_cnt   = 0;
  bit   rst_edge   = 1'b0;
  int   last_acc   = -1000;
  int   held_mag   = 0;
  int   held_phase = 0;
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   atan_tab[16];
  real  k_gain     = 1.0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp,
                            input int tol, input bit wrap);
    int d;
    d = act - exp;
    if (wrap) begin
      if (d > 32767) d -= 65536;
      else if (d < -32768) d += 65536;
    end
    n_checks++;
    if (d > tol || d < -tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d (t=%0t)", name, act, exp, tol, $time);
    end
  endtask

  // Arithmetic result of the fold + micro-rotation recipe on plain integers
  function automatic void model(input int i, input int q, output int m, output int p);
    int x, y, z, xt;
    bit zero;
    x = i; y = q; z = 0;
    zero = (i == 0) && (q == 0);
    if (x < 0) begin
      x = -x; y = -y; z = 32768;
    end
    for (int k = 0; k < int'(IT); k++) begin
      xt = x;
      if (y >= 0) begin
        x = x + (y >>> k);
        y = y - (xt >>> k);
        if (!zero) z = z + atan_tab[k];
      end else begin
        x = x - (y >>> k);
        y = y + (xt >>> k);
        if (!zero) z = z - atan_tab[k];
      end
    end
    p = z & 32'hFFFF;
`ifdef GAIN_COMP_EN
    m = (x * 1243) >>> 11;
`else
    m = x;
`endif
  endfunction

  // Loose agreement with true atan2/hypot for vectors large enough to resolve phase
  task automatic ideal_check(input int i, input int q, input int m, input int p);
    real h, ph, em;
    h = $sqrt(real'(i * i + q * q));
    if (h >= 1000.0) begin
      ph = $atan2(real'(q), real'(i)) * 65536.0 / (2.0 * PI);
      if (ph < 0.0) ph += 65536.0;
`ifdef GAIN_COMP_EN
      em = h;
`else
      em = h * k_gain;
`endif
      check_near("phase_vs_atan2", p, $rtoi(ph + 0.5), 96, 1'b1);
      check_near("mag_vs_hypot", m, $rtoi(em + 0.5), 16, 1'b0);
    end
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    rst_edge = rst;
  end

  // Cycle-by-cycle compare against the transaction model
  always @(negedge clk) begin
    bit exp_ready, exp_valid;
    int em, ep;
    if (rst_edge) begin
      pend.delete();
      last_acc   = -1000;
      held_mag   = 0;
      held_phase = 0;
    end
    exp_ready = (edge_cnt - last_acc) > int'(IT) + 1;
    check("in_ready", int'(in_ready), int'(exp_ready));
    exp_valid = (pend.size() > 0) && (pend[0].edge_n + int'(IT) + 1 == edge_cnt);
    check("out_valid", int'(out_valid), int'(exp_valid));
    if (exp_valid) begin
      model(pend[0].i, pend[0].q, em, ep);
      held_mag   = em;
      held_phase = ep;
      ideal_check(pend[0].i, pend[0].q, int'(mag), int'(phase));
      void'(pend.pop_front());
    end
    check("mag_o", int'(mag), held_mag);
    check("phase_o", int'(phase), held_phase);
    if (in_valid && exp_ready && !rst) begin
      pend.push_back('{edge_n: edge_cnt + 1, i: int'(i_s), q: int'(q_s)});
      last_acc = edge_cnt + 1;
    end
  end

  function automatic int rnd_sample();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic send(input int i, input int q);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    i_s = WD'(i);
    q_s = WD'(q);
    for (int n = 0; n < 40 && !acc; n++) begin
      @(posedge clk); #1;
      acc = (last_acc == edge_cnt);
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_result(output bit got);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = out_valid;
    end
    if (!got) check("result_timeout", 0, 1);
  endtask

  task automatic run_lit(input string name, input int i, input int q,
                         input int m_lit, input int p_lit);
    bit got;
    send(i, q);
    wait_result(got);
    if (got) begin
      check({name, "_mag"}, int'(mag), m_lit);
      check({name, "_phase"}, int'(phase), p_lit);
    end
  endtask

  initial begin
    int m, p;
    int corner_i[9] = '{-2048, 2047, -2048, 0, 2047, -1, 0, -1000, 0};
    int corner_q[9] = '{-2048, -2048, 0, -2048, 2047, 0, -1, -1000, -1000};

    for (int k = 0; k < 16; k++)
      atan_tab[k] = $rtoi($atan(1.0 / real'(1 << k)) * 65536.0 / (2.0 * PI) + 0.5);
    for (int k = 0; k < int'(IT); k++)
      k_gain = k_gain * $sqrt(1.0 + 1.0 / real'(1 << (2 * k)));

    // Hand-worked iterations pin the model
    model(1000, 0, m, p);
    check("pin_1000_0_phase", p, 11);
    model(0, 1000, m, p);
    check("pin_0_1000_phase", p, 16391);
`ifdef GAIN_COMP_EN
    check("pin_0_1000_mag", m, 999);
`else
    check("pin_0_1000_mag", m, 1647);
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_lit("zero", 0, 0, 0, 0);
`ifdef GAIN_COMP_EN
    run_lit("i1000", 1000, 0, 1000, 11);
    run_lit("q1000", 0, 1000, 999, 16391);
`else
    run_lit("i1000", 1000, 0, 1649, 11);
    run_lit("q1000", 0, 1000, 1647, 16391);
`endif

    for (int n = 0; n < 9; n++) send(corner_i[n], corner_q[n]);

    // Reset lands in the fifth micro-rotation cycle
    send(1000, 500);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_mag", int'(mag), 0);
    check("rst_phase", int'(phase), 0);
    send(0, -1000);

    // Continuous offer: only samples seen while idle are processed
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int n = 0; n < 70; n++) begin
      i_s = WD'(rnd_sample());
      q_s = WD'(rnd_sample());
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    for (int n = 0; n < 2048; n++) send(rnd_sample(), rnd_sample());

    repeat (24) @(posedge clk);
    #1 check("drain", pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
